mem_port_arbiter: RTL and testbench

Single-port memory arbiter that shares the core's one memory-controller port between the instruction-fetch stage (read-only) and the MA stage (read/write). It sits between the pipeline stages and the memory controller and is the only driver of the controller's read/write strobes, address, length and write-data lines. It grants one request at a time, issues a single-cycle strobe, waits for completion with a timeout, and returns data plus a one-cycle acknowledge to the winner. MA has priority, and a starvation limit guarantees that fetch makes progress.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_prio2.sv | 28 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter and the pipeline stages feeding it.
// Access-length encodings, default bus widths and arbiter FSM states.
package mem_port_arbiter_pkg;

  localparam int M_ADDR_L = 32;
  localparam int C_DATA_L = 32;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // The reserved length code 2'b11 is issued to the controller as a word access.
  function automatic logic [1:0] norm_len(input logic [1:0] len);
    return (len == 2'b11) ? LEN_WORD : len;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio2.sv
// Two-way priority select: MA wins ties unless fetch has been starved for starve_max grants.
// Purely combinational; produces a one-hot (or all-zero) grant.
module arb_prio2 #(
  parameter int CNT_W = 3
) (
  input  logic             if_req,
  input  logic             ma_req,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic [CNT_W-1:0] starve_max,
  output logic             gnt_if,
  output logic             gnt_ma
);

  logic if_starved;

  assign if_starved = if_req && (starve_cnt == starve_max);

  always_comb begin
    gnt_if = 1'b0;
    gnt_ma = 1'b0;
    if (ma_req && !if_starved) begin
      gnt_ma = 1'b1;
    end else if (if_req) begin
      gnt_if = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between fetch (read-only) and MA (read/write).
// Request-to-ack is k+2 cycles (k = strobe-to-mem_done), TIMEOUT+2 on timeout; one request in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MADDR_L    = M_ADDR_L,
  parameter int DATA_L     = C_DATA_L,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [MADDR_L-1:0] if_addr,
  output logic               if_ack,
  output logic [DATA_L-1:0]  if_rdata,
  output logic               if_err,
  input  logic               ma_req,
  input  logic               ma_we,
  input  logic [1:0]         ma_len,
  input  logic [MADDR_L-1:0] ma_addr,
  input  logic [DATA_L-1:0]  ma_wdata,
  output logic               ma_ack,
  output logic [DATA_L-1:0]  ma_rdata,
  output logic               ma_err,
  output logic               co_re,
  output logic               co_we,
  output logic [1:0]         co_len,
  output logic [MADDR_L-1:0] co_addr,
  output logic [DATA_L-1:0]  co_wdata,
  input  logic [DATA_L-1:0]  mem_rdata,
  input  logic               mem_done
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                sel_ma;
  logic                gnt_if;
  logic                gnt_ma;

  arb_prio2 #(.CNT_W(STARVE_W)) u_prio (
    .if_req     (if_req),
    .ma_req     (ma_req),
    .starve_cnt (starve_cnt),
    .starve_max (STARVE_W'(STARVE_MAX)),
    .gnt_if     (gnt_if),
    .gnt_ma     (gnt_ma)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      sel_ma     <= 1'b0;
      co_re      <= 1'b0;
      co_we      <= 1'b0;
      co_len     <= 2'b00;
      co_addr    <= '0;
      co_wdata   <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      ma_ack     <= 1'b0;
      ma_rdata   <= '0;
      ma_err     <= 1'b0;
    end else begin
      // Strobes, acks and errors are single-cycle pulses.
      co_re  <= 1'b0;
      co_we  <= 1'b0;
      if_ack <= 1'b0;
      if_err <= 1'b0;
      ma_ack <= 1'b0;
      ma_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (gnt_if || gnt_ma) begin
            sel_ma <= gnt_ma;
            if (gnt_ma) begin
              co_addr  <= ma_addr;
              co_len   <= norm_len(ma_len);
              co_wdata <= ma_wdata;
              co_re    <= !ma_we;
              co_we    <= ma_we;
            end else begin
              co_addr <= if_addr;
              co_len  <= LEN_WORD;
              co_re   <= 1'b1;
            end
            // Count only MA grants that actually made a pending fetch wait.
            if (gnt_if || !if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          // mem_done wins over the timeout when both land in the final cycle.
          if (mem_done) begin
            if (sel_ma) begin
              ma_ack   <= 1'b1;
              ma_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= ST_RESP;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            if (sel_ma) begin
              ma_ack   <= 1'b1;
              ma_err   <= 1'b1;
              ma_rdata <= '0;
            end else begin
              if_ack   <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= '0;
            end
            state <= ST_RESP;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus contention, stray-done and reset sequences.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          ma_req = 1'b0;
  logic          ma_we = 1'b0;
  logic [1:0]    ma_len = 2'b00;
  logic [AW-1:0] ma_addr = '0;
  logic [DW-1:0] ma_wdata = '0;
  logic          ma_ack;
  logic [DW-1:0] ma_rdata;
  logic          ma_err;
  logic          co_re;
  logic          co_we;
  logic [1:0]    co_len;
  logic [AW-1:0] co_addr;
  logic [DW-1:0] co_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MADDR_L(AW), .DATA_L(DW), .TIMEOUT(TO), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ma_req(ma_req), .ma_we(ma_we), .ma_len(ma_len), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_ack(ma_ack), .ma_rdata(ma_rdata), .ma_err(ma_err),
    .co_re(co_re), .co_we(co_we), .co_len(co_len), .co_addr(co_addr), .co_wdata(co_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no_ack required=ack_within_bound", name);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {56'b0, co_re, co_we, if_ack, ma_ack, if_err, ma_err, co_len}, 64'h0);
    check({tag, "_co_addr"}, 64'(co_addr), 64'h0);
    check({tag, "_co_wdata"}, 64'(co_wdata), 64'h0);
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'h0);
    check({tag, "_ma_rdata"}, 64'(ma_rdata), 64'h0);
  endtask

  // Scoreboard of expected acknowledges, in grant order.
  typedef struct {
    logic        is_ma;
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;
  exp_t sb[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (if_ack || ma_ack)) begin
        check("one_ack_only", {63'b0, if_ack & ma_ack}, 64'h0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack if_ack=%0b ma_ack=%0b required=none", if_ack, ma_ack);
        end else begin
          e = sb.pop_front();
          check("ack_port_is_ma", {63'b0, ma_ack}, {63'b0, e.is_ma});
          if (e.chk) check("ack_rdata", 64'(ma_ack ? ma_rdata : if_rdata), 64'(e.rdata));
          check("ack_err", {63'b0, ma_ack ? ma_err : if_err}, {63'b0, e.err});
        end
      end
    end
  end

  // Memory-controller model: mem_done k cycles after the strobe (k=0: never).
  logic [31:0] rd_val = '0;
  logic        rd_fixed = 1'b1;
  int          mem_k = 1;
  logic        stray = 1'b0;

  function automatic logic [31:0] mix(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    int cd;
    logic [31:0] a;
    cd = 0;
    a = '0;
    mem_done = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            mem_done = 1'b1;
            mem_rdata = rd_fixed ? rd_val : mix(a);
          end
        end
        if (co_re || co_we) begin
          a = co_addr;
          cd = mem_k;
        end
        if (stray) mem_done = 1'b1;
      end
    end
  end

  // Strobe monitor.
  int          st_cnt = 0;
  logic        st_re, st_we;
  logic [1:0]  st_len;
  logic [31:0] st_addr, st_wdata;
  initial forever begin
    @(negedge clk);
    if (co_re || co_we) begin
      st_cnt++;
      st_re = co_re;
      st_we = co_we;
      st_len = co_len;
      st_addr = co_addr;
      st_wdata = co_wdata;
    end
  end

  typedef struct {
    logic        is_ma;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          k;
    logic [1:0]  exp_len;
  } vec_t;

  task automatic single(input vec_t v, input string tag);
    logic is_err;
    int   exp_lat, t0;
    bit   ok;
    is_err = (v.k == 0) || (v.k > TO);
    exp_lat = is_err ? TO + 2 : v.k + 2;
    rd_fixed = 1'b1;
    rd_val = v.rd;
    mem_k = v.k;
    st_cnt = 0;
    sb.push_back('{is_ma: v.is_ma, rdata: is_err ? 32'h0 : v.rd, err: is_err, chk: !(v.is_ma && v.we)});
    if (v.is_ma) begin
      ma_we = v.we; ma_len = v.len; ma_addr = v.addr; ma_wdata = v.wdata; ma_req = 1'b1;
    end else begin
      if_addr = v.addr; if_req = 1'b1;
    end
    t0 = cyc;
    ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (if_ack || ma_ack) begin ok = 1; break; end
    end
    if_req = 1'b0;
    ma_req = 1'b0;
    if (!ok) begin
      bound_expired({tag, "_ack"});
    end else begin
      check({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
      check({tag, "_strobes"}, 64'(st_cnt), 64'd1);
      check({tag, "_re_we"}, {62'b0, st_re, st_we},
            {62'b0, !(v.is_ma && v.we), v.is_ma && v.we});
      check({tag, "_co_len"}, 64'(st_len), 64'(v.exp_len));
      check({tag, "_co_addr"}, 64'(st_addr), 64'(v.addr));
      if (v.is_ma && v.we) check({tag, "_co_wdata"}, 64'(st_wdata), 64'(v.wdata));
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  vec_t vt[9];
  bit   seen;

  initial begin
    vt[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2,  2'b10};
    vt[1] = '{1'b1, 1'b1, 2'b01, 32'h0000_0204, 32'h0000_1234, 32'h0,         1,  2'b01};
    vt[2] = '{1'b1, 1'b0, 2'b00, 32'h0000_0003, 32'h0,         32'h1122_3344, 1,  2'b00};
    vt[3] = '{1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h0,         32'hCAFE_F00D, 3,  2'b10};
    vt[4] = '{1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h0,         32'h7777_7777, 0,  2'b10};
    vt[5] = '{1'b0, 1'b0, 2'b10, 32'h0000_0600, 32'h0,         32'h0BAD_F00D, 1,  2'b10};
    vt[6] = '{1'b1, 1'b0, 2'b10, 32'h0000_0700, 32'h0,         32'h1357_9BDF, TO, 2'b10};
    vt[7] = '{1'b0, 1'b0, 2'b10, 32'h0000_0800, 32'h0,         32'h2468_ACE0, TO + 1, 2'b10};
    vt[8] = '{1'b1, 1'b1, 2'b10, 32'h0000_0904, 32'hA5A5_5A5A, 32'h0,         5,  2'b10};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 9; i++) single(vt[i], $sformatf("vec%0d", i));

    // Stray mem_done while idle must not produce an ack or disturb the FSM.
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | if_ack | ma_ack | co_re | co_we;
    end
    check("stray_done_no_activity", {63'b0, seen}, 64'h0);
    single('{1'b0, 1'b0, 2'b10, 32'h0000_0A00, 32'h0, 32'h600D_D00D, 1, 2'b10}, "post_stray");

    // Contention: expected grant order MA x4, IF, MA x4, IF.
    rd_fixed = 1'b0;
    mem_k = 1;
    for (int i = 0; i < 4; i++) sb.push_back('{1'b1, mix(32'h2000 + 32'(4 * i)), 1'b0, 1'b1});
    sb.push_back('{1'b0, mix(32'h1000), 1'b0, 1'b1});
    for (int i = 4; i < 8; i++) sb.push_back('{1'b1, mix(32'h2000 + 32'(4 * i)), 1'b0, 1'b1});
    sb.push_back('{1'b0, mix(32'h1004), 1'b0, 1'b1});
    fork
      begin
        bit ok_ma;
        for (int i = 0; i < 8; i++) begin
          ma_we = 1'b0; ma_len = 2'b10; ma_addr = 32'h2000 + 32'(4 * i); ma_req = 1'b1;
          ok_ma = 0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ma_ack) begin ok_ma = 1; break; end
          end
          if (!ok_ma) begin bound_expired("contention_ma"); break; end
        end
        ma_req = 1'b0;
      end
      begin
        bit ok_if;
        for (int i = 0; i < 2; i++) begin
          if_addr = 32'h1000 + 32'(4 * i); if_req = 1'b1;
          ok_if = 0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (if_ack) begin ok_if = 1; break; end
          end
          if (!ok_if) begin bound_expired("contention_if"); break; end
        end
        if_req = 1'b0;
      end
    join
    @(negedge clk);
    check("contention_sb_drained", 64'(sb.size()), 64'h0);
    @(negedge clk);

    // Reset while waiting on the controller: outputs clear at once, no ack follows.
    rd_fixed = 1'b1;
    mem_k = 0;
    if_addr = 32'h0000_3000;
    if_req = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    sb.delete();
    if_req = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | if_ack | ma_ack;
    end
    check("no_ack_after_reset", {63'b0, seen}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    single('{1'b0, 1'b0, 2'b10, 32'h0000_3000, 32'h0, 32'h0F0F_F0F0, 1, 2'b10}, "post_reset");

    repeat (2) @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
